// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and default sizes.
package fetch_unit_pkg;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_ADDR_WIDTH     = 8;
    localparam int DEF_WORD_BYTE_SIZE = 1;
    localparam int DEF_STARTUP_CYCLES = 48;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_READ    = 2'd2,
        ST_HOLD    = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, its instruction memory and the decode stage.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int DataWidth = DEF_DATA_WIDTH,
    parameter int AddrWidth = DEF_ADDR_WIDTH
) ();

    logic                 Branch_Req;
    logic [AddrWidth-1:0] Branch_Addr;
    logic [DataWidth-1:0] Mem_DIn;
    logic                 IR_Ready;
    logic [AddrWidth-1:0] Mem_Addr;
    logic                 Mem_En_N;
    logic                 Mem_Wr_N;
    logic [DataWidth-1:0] IR;
    logic [AddrWidth-1:0] IR_PC;
    logic                 IR_Valid;

    // IR/IR_PC are offered while IR_Valid=1 and stay stable until consumed; the
    // instruction is consumed on a rising edge where IR_Valid and IR_Ready are both 1.
    modport master (
        input  Branch_Req, Branch_Addr, Mem_DIn, IR_Ready,
        output Mem_Addr, Mem_En_N, Mem_Wr_N, IR, IR_PC, IR_Valid
    );

    modport slave (
        output Branch_Req, Branch_Addr, Mem_DIn, IR_Ready,
        input  Mem_Addr, Mem_En_N, Mem_Wr_N, IR, IR_PC, IR_Valid
    );

endinterface

// File: rtl/fetch_unit_startup_timer.sv
// Post-reset settle counter: Done rises after StartupCycles clocks and then stays high.
module startup_timer
    import fetch_unit_pkg::*;
#(
    parameter int StartupCycles = DEF_STARTUP_CYCLES
) (
    input  logic Clk,
    input  logic Reset,
    output logic Done
);

    localparam int CntW = (StartupCycles > 1) ? $clog2(StartupCycles) : 1;
    localparam logic [CntW-1:0] Last = CntW'(StartupCycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Saturate on the last count so Done holds until the next reset.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != Last) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Done = (cnt_q == Last);

endmodule

// File: rtl/fetch_unit.sv
// Three-clock instruction fetch FSM (ISSUE, READ, HOLD) with branch redirect.
// Build macro FETCH_STARTUP_DELAY_EN enables the StartupCycles post-reset delay.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   DataWidth     = DEF_DATA_WIDTH,
    parameter int                   AddrWidth     = DEF_ADDR_WIDTH,
    parameter int                   WordByteSize  = DEF_WORD_BYTE_SIZE,
    parameter int                   StartupCycles = DEF_STARTUP_CYCLES,
    parameter logic [AddrWidth-1:0] ResetVector   = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_unit_if.master bus,
    output fetch_state_e dbg_state_o
);

    fetch_state_e         state_q;
    logic [AddrWidth-1:0] pc_q;
    logic [AddrWidth-1:0] mem_addr_q;
    logic                 mem_en_n_q;
    logic [DataWidth-1:0] ir_q;
    logic [AddrWidth-1:0] ir_pc_q;
    logic                 ir_valid_q;
    logic                 startup_done;

`ifdef FETCH_STARTUP_DELAY_EN
    startup_timer #(
        .StartupCycles(StartupCycles)
    ) u_startup_timer (
        .Clk  (Clk),
        .Reset(Reset),
        .Done (startup_done)
    );
`else
    // Delay compiled out: STARTUP always lasts one clock, whatever StartupCycles says.
    assign startup_done = 1'b1 | (StartupCycles == 0);
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_STARTUP;
            pc_q       <= ResetVector;
            mem_addr_q <= ResetVector;
            mem_en_n_q <= 1'b1;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else if (state_q == ST_STARTUP) begin
            // A redirect during startup only moves the PC; the delay keeps running.
            if (bus.Branch_Req) begin
                pc_q <= bus.Branch_Addr;
            end
            if (startup_done) begin
                state_q    <= ST_ISSUE;
                mem_en_n_q <= 1'b0;
                mem_addr_q <= bus.Branch_Req ? bus.Branch_Addr : pc_q;
            end
        end else if (bus.Branch_Req) begin
            pc_q       <= bus.Branch_Addr;
            mem_addr_q <= bus.Branch_Addr;
            mem_en_n_q <= 1'b0;
            ir_valid_q <= 1'b0;
            state_q    <= ST_ISSUE;
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    mem_en_n_q <= 1'b1;
                    state_q    <= ST_READ;
                end
                ST_READ: begin
                    ir_q       <= bus.Mem_DIn;
                    ir_pc_q    <= pc_q;
                    ir_valid_q <= 1'b1;
                    pc_q       <= pc_q + AddrWidth'(WordByteSize);
                    state_q    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.IR_Ready) begin
                        ir_valid_q <= 1'b0;
                        mem_addr_q <= pc_q;
                        mem_en_n_q <= 1'b0;
                        state_q    <= ST_ISSUE;
                    end
                end
                default: begin
                    state_q <= ST_STARTUP;
                end
            endcase
        end
    end

    assign bus.Mem_Addr = mem_addr_q;
    assign bus.Mem_En_N = mem_en_n_q;
    assign bus.Mem_Wr_N = 1'b1;
    assign bus.IR       = ir_q;
    assign bus.IR_PC    = ir_pc_q;
    assign bus.IR_Valid = ir_valid_q;
    assign dbg_state_o  = state_q;

endmodule
